// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the dual-clock FIFO: drains the FIFO read port into a
// valid/ready stream through a 2-entry skid buffer and frames packets with O_last.
module fifo_stream_reader #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned PKT_LEN   = 16,
    parameter int unsigned CNTWIDTH  = 16
) (
    input  logic                 clk_rd,
    input  logic                 rrst_n,
    input  logic                 I_enable,
    input  logic                 I_empty,
    output logic                 O_rden,
    input  logic [DATAWIDTH-1:0] I_rdata,
    output logic                 O_valid,
    input  logic                 I_ready,
    output logic [DATAWIDTH-1:0] O_data,
    output logic                 O_last,
    output logic                 O_busy,
    output logic [CNTWIDTH-1:0]  O_word_cnt
);

    localparam int unsigned IDXW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATAWIDTH-1:0] slot0;
    logic [DATAWIDTH-1:0] slot1;
    logic [DATAWIDTH-1:0] slot0_nxt;
    logic [DATAWIDTH-1:0] slot1_nxt;
    logic [1:0]           occ;
    logic                 inflight;
    logic [IDXW-1:0]      idx;
    logic [CNTWIDTH-1:0]  word_cnt;
    logic                 pop;
    logic [1:0]           pending;
    logic [1:0]           tail;

    assign O_valid    = (occ != 2'd0);
    assign O_data     = slot0;
    assign O_last     = O_valid & (idx == LAST_IDX);
    assign O_busy     = (state != IDLE);
    assign O_word_cnt = word_cnt;
    assign pop        = O_valid & I_ready;

    // Words still owed to the buffer after this cycle; also the next occupancy.
    assign pending = occ + {1'b0, inflight} - {1'b0, pop};
    assign tail    = occ - {1'b0, pop};
    assign O_rden  = rrst_n & I_enable & ~I_empty & (pending < 2'd2);

    // Shift on pop, then land the in-flight word at the new tail.
    always_comb begin
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        if (pop) begin
            slot0_nxt = slot1;
        end
        if (inflight) begin
            if (tail == 2'd0) begin
                slot0_nxt = I_rdata;
            end else begin
                slot1_nxt = I_rdata;
            end
        end
    end

    always_ff @(posedge clk_rd) begin
        if (!rrst_n) begin
            slot0    <= '0;
            slot1    <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            idx      <= '0;
            word_cnt <= '0;
        end else begin
            slot0    <= slot0_nxt;
            slot1    <= slot1_nxt;
            occ      <= pending;
            inflight <= O_rden;
            if (pop) begin
                word_cnt <= word_cnt + CNTWIDTH'(1);
                idx      <= O_last ? '0 : idx + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk_rd) begin
        if (!rrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reads are disabled whenever I_enable is low, so pending alone tells us
    // whether anything is still owed when leaving RUN or DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (I_enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!I_enable) begin
                    state_nxt = (pending != 2'd0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (I_enable) begin
                    state_nxt = RUN;
                end else if (pending == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_rd) begin
        if (rrst_n) begin
            assert ({1'b0, occ} + {2'b00, inflight} <= 3'd2)
                else $error("skid buffer overflow: occ=%0d inflight=%0d", occ, inflight);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO and stream model checked every
// cycle, a directed vector table for the basic stream, and corner-case sequences.
module tb_fifo_stream_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned PL = 4;
    localparam int unsigned CW = 4;

    logic          clk_rd = 1'b0;
    logic          rrst_n;
    logic          I_enable;
    logic          I_empty;
    logic          O_rden;
    logic [DW-1:0] I_rdata;
    logic          O_valid;
    logic          I_ready;
    logic [DW-1:0] O_data;
    logic          O_last;
    logic          O_busy;
    logic [CW-1:0] O_word_cnt;

    always #5 clk_rd = ~clk_rd;

    fifo_stream_reader #(.DATAWIDTH(DW), .PKT_LEN(PL), .CNTWIDTH(CW)) dut (
        .clk_rd    (clk_rd),
        .rrst_n    (rrst_n),
        .I_enable  (I_enable),
        .I_empty   (I_empty),
        .O_rden    (O_rden),
        .I_rdata   (I_rdata),
        .O_valid   (O_valid),
        .I_ready   (I_ready),
        .O_data    (O_data),
        .O_last    (O_last),
        .O_busy    (O_busy),
        .O_word_cnt(O_word_cnt)
    );

    typedef struct {
        bit            en;
        bit            rdy;
        bit            rden;
        bit            valid;
        logic [DW-1:0] data;
        bit            last;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo[$];       // words sitting in the external FIFO
    logic [DW-1:0] pend[$];       // words read from the FIFO, not yet popped (incl. in flight)
    bit            m_inf;
    int            m_idx;
    int            m_cnt;
    bit            m_busy;
    bit            m_known = 1'b0;

    bit            s_rden, s_valid, s_last, s_busy;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt;

    int            pops;
    logic [DW-1:0] popped[$];
    bit            popped_last[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample and compare, then advance the model.
    task automatic step(input bit en, input bit rdy, input bit rst);
        int            vis;
        bit            m_valid, m_last, m_pop, m_rden;
        logic [DW-1:0] word;
        rrst_n   = rst;
        I_enable = en;
        I_ready  = rdy;
        I_empty  = (fifo.size() == 0);
        #1;
        s_rden  = O_rden;
        s_valid = O_valid;
        s_data  = O_data;
        s_last  = O_last;
        s_busy  = O_busy;
        s_cnt   = O_word_cnt;

        vis     = pend.size() - int'(m_inf);
        m_valid = m_known && (vis > 0);
        m_last  = m_valid && (m_idx == PL - 1);
        m_pop   = rst && m_valid && rdy;
        m_rden  = rst && en && (fifo.size() > 0) && (vis + int'(m_inf) - int'(m_pop) < 2);

        chk("rden", 64'(s_rden), 64'(m_rden));
        if (m_known) begin
            chk("valid", 64'(s_valid), 64'(m_valid));
            if (m_valid) begin
                chk("data", 64'(s_data), 64'(pend[0]));
                chk("last", 64'(s_last), 64'(m_last));
            end
            chk("word_cnt", 64'(s_cnt), 64'(m_cnt));
            chk("busy", 64'(s_busy), 64'(m_busy));
        end
        if (m_pop) begin
            popped.push_back(s_data);
            popped_last.push_back(s_last);
            pops++;
        end

        @(posedge clk_rd);
        word = (fifo.size() > 0) ? fifo[0] : '0;
        if (!rst) begin
            pend.delete();
            m_inf   = 1'b0;
            m_idx   = 0;
            m_cnt   = 0;
            m_busy  = 1'b0;
            m_known = 1'b1;
        end else begin
            if (m_pop) begin
                void'(pend.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_idx = m_last ? 0 : m_idx + 1;
            end
            if (m_rden) pend.push_back(word);
            m_inf  = m_rden;
            m_busy = en || (m_busy && (pend.size() > 0));
        end
        #1;
        if (s_rden && fifo.size() > 0) I_rdata = fifo.pop_front();
        @(negedge clk_rd);
    endtask

    task automatic run_pops(input int n, input bit rand_rdy, input int bound, input string name);
        int c;
        c = 0;
        while (pops < n && c < bound) begin
            step(1'b1, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1);
            c++;
        end
        chk({name, "_pops"}, 64'(pops), 64'(n));
    endtask

    vec_t          t2[11];
    logic [DW-1:0] sent[$];
    bit            busy_hist[6];

    initial begin
        rrst_n   = 1'b0;
        I_enable = 1'b0;
        I_empty  = 1'b1;
        I_ready  = 1'b0;
        I_rdata  = '0;

        // Back-to-back stream of 0x10..0x17, PKT_LEN=4, ready always high.
        t2[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        t2[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        t2[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0};
        t2[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0};
        t2[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h12, 1'b0};
        t2[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h13, 1'b1};
        t2[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0};
        t2[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h15, 1'b0};
        t2[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h16, 1'b0};
        t2[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h17, 1'b1};
        t2[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};

        @(negedge clk_rd);

        // T1: reset held with a non-empty FIFO and enable high
        for (int i = 0; i < 8; i++) fifo.push_back(DW'(32'h10 + i));
        repeat (3) step(1'b1, 1'b1, 1'b0);
        #1;
        chk("t1_rden", 64'(O_rden), 64'd0);
        chk("t1_valid", 64'(O_valid), 64'd0);
        chk("t1_cnt", 64'(O_word_cnt), 64'd0);
        chk("t1_data", 64'(O_data), 64'd0);
        chk("t1_busy", 64'(O_busy), 64'd0);

        // T2: directed vectors
        for (int k = 0; k < 11; k++) begin
            step(t2[k].en, t2[k].rdy, 1'b1);
            chk("t2_rden", 64'(s_rden), 64'(t2[k].rden));
            chk("t2_valid", 64'(s_valid), 64'(t2[k].valid));
            if (t2[k].valid) begin
                chk("t2_data", 64'(s_data), 64'(t2[k].data));
                chk("t2_last", 64'(s_last), 64'(t2[k].last));
            end
        end
        chk("t2_cnt", 64'(s_cnt), 64'd8);

        // T3: random backpressure, 100 words in order
        for (int i = 0; i < 100; i++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            fifo.push_back(w);
            sent.push_back(w);
        end
        pops = 0;
        popped.delete();
        popped_last.delete();
        run_pops(100, 1'b1, 2000, "t3");
        for (int i = 0; i < 100 && i < popped.size(); i++) chk("t3_order", 64'(popped[i]), 64'(sent[i]));

        // T4: FIFO runs dry mid-packet (108 pops so far -> packet index 0)
        repeat (2) step(1'b1, 1'b1, 1'b1);
        pops = 0;
        popped.delete();
        popped_last.delete();
        fifo.push_back(32'hA0);
        fifo.push_back(32'hA1);
        repeat (6) step(1'b1, 1'b1, 1'b1);
        chk("t4_pops_dry", 64'(pops), 64'd2);
        chk("t4_valid_dry", 64'(s_valid), 64'd0);
        fifo.push_back(32'hA2);
        fifo.push_back(32'hA3);
        repeat (6) step(1'b1, 1'b1, 1'b1);
        chk("t4_pops", 64'(pops), 64'd4);
        for (int i = 0; i < 4 && i < popped_last.size(); i++)
            chk("t4_last", 64'(popped_last[i]), 64'(i == 3));

        // T5: fill the buffer, pop once while reading, then disable and drain
        for (int i = 0; i < 5; i++) fifo.push_back(DW'(32'hB0 + i));
        repeat (4) step(1'b1, 1'b0, 1'b1);
        pops = 0;
        step(1'b1, 1'b1, 1'b1);
        chk("t5_rden_en", 64'(s_rden), 64'd1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1);
            busy_hist[i] = s_busy;
            chk("t5_no_read", 64'(s_rden), 64'd0);
        end
        chk("t5_pops", 64'(pops), 64'd3);
        chk("t5_drain_busy", 64'(busy_hist[1]), 64'd1);
        chk("t5_idle", 64'(busy_hist[2]), 64'd0);
        chk("t5_fifo_left", 64'(fifo.size()), 64'd2);

        // T6: counter wrap at 4 bits, then reset mid-packet
        fifo.delete();
        repeat (2) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) fifo.push_back(DW'($urandom));
        pops = 0;
        run_pops(17, 1'b1, 400, "t6_wrap");
        step(1'b1, 1'b0, 1'b1);
        chk("t6_cnt_wrap", 64'(s_cnt), 64'd1);
        for (int i = 0; i < 6; i++) fifo.push_back(DW'(32'hC0 + i));
        pops = 0;
        run_pops(2, 1'b0, 20, "t6_mid");
        repeat (2) step(1'b1, 1'b0, 1'b1);
        fifo.delete();
        repeat (2) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) fifo.push_back(DW'(32'hD0 + i));
        pops = 0;
        popped.delete();
        popped_last.delete();
        run_pops(8, 1'b1, 200, "t6_post");
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            chk("t6_data", 64'(popped[i]), 64'(32'hD0 + i));
            chk("t6_last", 64'(popped_last[i]), 64'(i == 3 || i == 7));
        end

        // T7: random enable, ready, FIFO fill and rare resets against the model
        for (int c = 0; c < 500; c++) begin
            if (fifo.size() < 8 && $urandom_range(0, 1) == 1) fifo.push_back(DW'($urandom));
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
